// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the E stage.
// Results are computed when the operation is accepted and published when the busy period ends.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
  logic        pend_ok, pend_ok_nx;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_ovf;
  logic signed [31:0] dvs_s, quot_s, rem_s;
  logic        [31:0] dvs_u, quot_u, rem_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Zero and overflow divisors are replaced by 1 so the dividers never see an
  // undefined case; overflow then yields a/1 = 0x80000000 rem 0 as required.
  assign div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign dvs_s   = (src_b == 32'd0 || div_ovf) ? 32'sd1 : $signed(src_b);
  assign dvs_u   = (src_b == 32'd0) ? 32'd1 : src_b;
  assign quot_s  = $signed(src_a) / dvs_s;
  assign rem_s   = $signed(src_a) % dvs_s;
  assign quot_u  = src_a / dvs_u;
  assign rem_u   = src_a % dvs_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      pend_ok <= pend_ok_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi;
    lo_nx      = lo;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    pend_ok_nx = pend_ok;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            3'd0: begin
              {pend_hi_nx, pend_lo_nx} = prod_s;
              pend_ok_nx = 1'b1;
              cnt_nx     = 5'(MULT_CYCLES);
              state_nx   = RUN;
            end
            3'd1: begin
              {pend_hi_nx, pend_lo_nx} = prod_u;
              pend_ok_nx = 1'b1;
              cnt_nx     = 5'(MULT_CYCLES);
              state_nx   = RUN;
            end
            3'd2: begin
              pend_hi_nx = rem_s;
              pend_lo_nx = quot_s;
              pend_ok_nx = (src_b != 32'd0);
              cnt_nx     = 5'(DIV_CYCLES);
              state_nx   = RUN;
            end
            3'd3: begin
              pend_hi_nx = rem_u;
              pend_lo_nx = quot_u;
              pend_ok_nx = (src_b != 32'd0);
              cnt_nx     = 5'(DIV_CYCLES);
              state_nx   = RUN;
            end
            3'd4:    hi_nx = src_a;
            3'd5:    lo_nx = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 5'd1;
        if (cnt <= 5'd1) begin
          cnt_nx   = 5'd0;
          state_nx = IDLE;
          if (pend_ok) begin
            hi_nx = pend_hi;
            lo_nx = pend_lo;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, busy length, HI/LO hold, mthi/mtlo and reset abort.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails  = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a multi-cycle op, measure busy length and confirm HI/LO hold while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h0, l0;
    int cnt;
    int moved;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; moved = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (hi !== h0 || lo !== l0) moved++;
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, 32'(cnt), 32'(n));
    chk({tag, "_hold"}, 32'(moved), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic quick(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf",3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",  3'd3, 32'd100,       32'd7,         10, 32'd2,         32'd14);

    quick(3'd4, 32'h11);
    chk("mthi11_hi", hi, 32'h11);
    quick(3'd5, 32'h22);
    chk("mtlo22_lo", lo, 32'h22);
    chk("mtlo22_hi", hi, 32'h11);

    run_op("divu0", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);

    quick(3'd4, 32'h1234);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    quick(3'd6, 32'hDEAD);
    chk("rsv_hi", hi, 32'h1234);
    chk("rsv_lo", lo, 32'h22);
    chk("rsv_busy", {31'd0, busy}, 32'd0);

    // Abort scenario: div in flight, mtlo attempted mid-run, then async reset.
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'hAAAA;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_ignored", lo, 32'h22);
    chk("abort_busy3", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("late_hi", hi, 32'd0);
    chk("late_lo", lo, 32'd0);
    chk("late_busy", {31'd0, busy}, 32'd0);

    run_op("post", 3'd0, 32'd7, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
